ntt_polyvec_coef_streamer: RTL and testbench
============================================

Name: ntt_polyvec_coef_streamer

Overview:
- Downstream consumer of the packed NTT polyvec BRAM written by the forward-NTT stage. Each BRAM word is 96 bits: 8 coefficients of 12 bits each. Poly 0 sits at addresses 0..31 and poly 1 at addresses 32..63.
- Reads the words back, unpacks them, and streams one 12-bit coefficient per cycle over a valid/ready handshake into the pointwise basemul/accumulate stage.
- Flags any coefficient that is not fully reduced (value >= KYBER_Q).

Parameters:
- KYBER_K, 2, number of polynomials streamed per run.
- KYBER_N, 256, coefficients per polynomial.
- KYBER_Q, 3329, modulus used for the range check.
- COEF_W, 12, coefficient width.
- WORD_W, 96, BRAM word width (8 coefficients per word).
- ADDR_W, 6, BRAM address width (KYBER_K*KYBER_N/8 = 64 words).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- bram_rd_en  out  1  BRAM read enable.
- bram_rd_addr  out  ADDR_W  BRAM read address.
- bram_rd_data  in  WORD_W  BRAM read data; valid on the cycle after the edge that captures addr/en.
- coef_data  out  COEF_W  current coefficient.
- coef_poly  out  1  polynomial index of coef_data.
- coef_idx  out  8  coefficient index within its polynomial (0..255).
- coef_last  out  1  high with the final coefficient of the run (poly KYBER_K-1, idx 255).
- coef_valid  out  1  coefficient valid.
- coef_ready  in  1  downstream accepts.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last handshake.
- range_err  out  1  sticky: some streamed coefficient was >= KYBER_Q; cleared on start.

Behaviour:
- Reset: rst_n=0 at any clock edge forces IDLE. All outputs go to 0 (bram_rd_en, bram_rd_addr, coef_*, busy, done, range_err). Internal word buffers are invalidated. Reset mid-run abandons the run with no done pulse.
- States:
  - IDLE -> FILL on start; busy=1 and range_err cleared on that edge.
  - FILL -> STREAM once the first word is buffered.
  - STREAM -> FINISH on the handshake of coef_last.
  - FINISH -> IDLE after one cycle, with done=1 during FINISH.
- start while not in IDLE is ignored.
- Word unpack order: coefficient k of a word is bits [95-12k -: 12]. Coefficient 0 is in the MSBs.
  - Example: word address w, slot k -> poly = w/32, idx = (w%32)*8 + k.
- Handshake:
  - A transfer occurs on any edge with coef_valid & coef_ready.
  - While coef_valid=1 and coef_ready=0, coef_data, coef_poly, coef_idx and coef_last hold stable, and coef_valid stays 1.
  - coef_valid never drops until the transfer completes.
- Latency: start sampled at edge S.
  - bram_rd_en=1 with addr 0 from edge S+1.
  - Word 0 is buffered at edge S+3.
  - coef_valid first rises after edge S+3.
- Throughput:
  - Two-entry word buffer (current + prefetch). The next read is issued so that, with coef_ready held at 1, exactly KYBER_K*KYBER_N coefficients transfer on consecutive cycles with no bubbles.
  - A read is issued only when a buffer slot is guaranteed free on data return; no BRAM word is ever dropped or read twice.
  - bram_rd_en stays 0 after address KYBER_K*KYBER_N/8-1 has been issued.
- Address: increments by 1 per read issued, from 0 to 63, with no wrap within a run. It returns to 0 in IDLE.
- Range check: on each transfer, if coef_data >= KYBER_Q (unsigned 12-bit compare), range_err is set on that edge. range_err holds until the next accepted start or reset. The check never alters the data.
- Backpressure at the end of a word: if coef_ready is low on slot 7 while the prefetch slot is full, no further read is issued until a slot frees.
- coef_last together with coef_ready=0: done waits until coef_last is accepted.
- start asserted in the same cycle as the done pulse: ignored, because the state is not IDLE. start is accepted on the following IDLE cycle.

Test Plan:
- Memory preloaded with word w = 8 coefficients {8w, 8w+1, ..., 8w+7}, start pulse, coef_ready=1.
  - First coef_valid after edge S+3 carries data 0, poly 0, idx 0.
  - 512 consecutive transfers with data == running count.
  - Poly flips to 1 at transfer 256; coef_last on data 511; done exactly one cycle later; range_err=0.
- Same image, coef_ready toggled in a random pattern (about 50%).
  - Identical ordered sequence of 512 values, no duplicates or gaps.
  - Outputs stable during every stall cycle; BRAM addresses issued 0..63 exactly once each.
- Word 5, slot 3 set to 3329; word 40, slot 0 set to 4095.
  - range_err rises on the edge accepting poly 0 idx 43 and stays high.
  - Cleared at the next start; the value 3328 alone never sets it.
- coef_ready=0 held for 20 cycles with coef_last presented.
  - coef_last and data stable throughout, done low.
  - Release -> done pulse the cycle after the handshake.
- rst_n=0 for one edge at transfer 100.
  - All outputs 0, state IDLE, no done pulse.
  - A new start restarts from addr 0, idx 0.
- start pulsed during STREAM and in the done cycle -> ignored, coefficient sequence unaffected. A second start in IDLE produces a full second run.

Source files
------------

// File: rtl/ntt_polyvec_coef_streamer.sv
// Streams the packed NTT polyvec BRAM back out one 12-bit coefficient per cycle
// over valid/ready, flagging any coefficient that is not fully reduced mod q.
module ntt_polyvec_coef_streamer #(
  parameter int KYBER_K = 2,
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329,
  parameter int COEF_W  = 12,
  parameter int WORD_W  = 96,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              bram_rd_en,
  output logic [ADDR_W-1:0] bram_rd_addr,
  input  logic [WORD_W-1:0] bram_rd_data,
  output logic [COEF_W-1:0] coef_data,
  output logic              coef_poly,
  output logic [7:0]        coef_idx,
  output logic              coef_last,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              busy,
  output logic              done,
  output logic              range_err
);

  localparam int COEFS_PER_WORD = WORD_W / COEF_W;
  localparam int TOTAL          = KYBER_K * KYBER_N;
  localparam int WORDS          = TOTAL / COEFS_PER_WORD;
  localparam int CNT_W          = $clog2(TOTAL);
  localparam int SLOT_W         = $clog2(COEFS_PER_WORD);
  localparam int ISS_W          = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TOTAL - 1);
  localparam logic [ISS_W-1:0]  WORDS_ISS = ISS_W'(WORDS);
  localparam logic [COEF_W-1:0] Q_C       = COEF_W'(KYBER_Q);
  localparam logic [SLOT_W-1:0] LAST_SLOT = {SLOT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Coefficient 0 of a word occupies the most significant bits.
  function automatic logic [COEF_W-1:0] unpack_coef(input logic [WORD_W-1:0] word,
                                                    input logic [SLOT_W-1:0] slot);
    logic [WORD_W-1:0] shifted;
    shifted = word >> (COEF_W * (COEFS_PER_WORD - 1 - int'(slot)));
    return shifted[COEF_W-1:0];
  endfunction

  function automatic logic unreduced(input logic [COEF_W-1:0] c);
    return (c >= Q_C);
  endfunction

  state_t              state_r, state_s;
  logic [WORD_W-1:0]   cur_word_r, cur_word_s;
  logic [WORD_W-1:0]   pf_word_r, pf_word_s;
  logic                cur_vld_r, cur_vld_s;
  logic                pf_vld_r, pf_vld_s;
  logic                ret_vld_r;
  logic                rd_en_r;
  logic [ADDR_W-1:0]   rd_addr_r, rd_addr_s;
  logic [ISS_W-1:0]    iss_cnt_r, iss_cnt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [COEF_W-1:0]   coef_data_r, coef_data_s;
  logic                coef_last_r, coef_last_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                range_err_r, range_err_s;

  logic                accept_s;
  logic                active_s;
  logic                xfer_s;
  logic                consume_s;
  logic                cur_free_s;
  logic                issue_s;
  logic [2:0]          occ_s;

  // Next-state logic of the run sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:   state_s = start ? S_FILL : S_IDLE;
      S_FILL:   state_s = ret_vld_r ? S_STREAM : S_FILL;
      S_STREAM: state_s = (xfer_s && coef_last_r) ? S_FINISH : S_STREAM;
      S_FINISH: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // Handshake, read credit and word-buffer steering.
  always_comb begin
    accept_s   = (state_r == S_IDLE) && start;
    active_s   = (state_r == S_FILL) || (state_r == S_STREAM);
    xfer_s     = cur_vld_r && coef_ready;
    consume_s  = xfer_s && (cnt_r[SLOT_W-1:0] == LAST_SLOT);
    cur_free_s = !cur_vld_r || consume_s;
    // Buffered words plus reads in flight; a read may only go out when
    // a slot is certain to be free by the time its data returns.
    occ_s      = {2'b00, cur_vld_r} + {2'b00, pf_vld_r} + {2'b00, rd_en_r} + {2'b00, ret_vld_r};
    issue_s    = active_s && (iss_cnt_r < WORDS_ISS) && (occ_s < (3'd2 + {2'b00, consume_s}));

    cur_word_s = cur_word_r;
    cur_vld_s  = cur_vld_r;
    pf_word_s  = pf_word_r;
    pf_vld_s   = pf_vld_r;
    if (cur_free_s) begin
      if (pf_vld_r) begin
        cur_word_s = pf_word_r;
        cur_vld_s  = 1'b1;
        pf_vld_s   = ret_vld_r;
        pf_word_s  = ret_vld_r ? bram_rd_data : pf_word_r;
      end else begin
        cur_vld_s  = ret_vld_r;
        cur_word_s = ret_vld_r ? bram_rd_data : cur_word_r;
      end
    end else begin
      if (ret_vld_r) begin
        pf_word_s = bram_rd_data;
        pf_vld_s  = 1'b1;
      end else begin
        pf_vld_s  = pf_vld_r;
      end
    end
  end

  // Counters and registered output values.
  always_comb begin
    if (accept_s) begin
      cnt_s = '0;
    end else if (xfer_s) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end

    if (accept_s) begin
      iss_cnt_s = '0;
    end else if (issue_s) begin
      iss_cnt_s = iss_cnt_r + ISS_W'(1);
    end else begin
      iss_cnt_s = iss_cnt_r;
    end

    if (issue_s) begin
      rd_addr_s = iss_cnt_r[ADDR_W-1:0];
    end else if (state_s == S_IDLE) begin
      rd_addr_s = '0;
    end else begin
      rd_addr_s = rd_addr_r;
    end

    coef_data_s = unpack_coef(cur_word_s, cnt_s[SLOT_W-1:0]);
    coef_last_s = cur_vld_s && (cnt_s == LAST_CNT);

    if (accept_s) begin
      range_err_s = 1'b0;
    end else if (xfer_s && unreduced(coef_data_r)) begin
      range_err_s = 1'b1;
    end else begin
      range_err_s = range_err_r;
    end

    if (accept_s) begin
      busy_s = 1'b1;
    end else if (state_r == S_FINISH) begin
      busy_s = 1'b0;
    end else begin
      busy_s = busy_r;
    end

    done_s = (state_r == S_STREAM) && xfer_s && coef_last_r;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cur_word_r  <= '0;
      pf_word_r   <= '0;
      cur_vld_r   <= 1'b0;
      pf_vld_r    <= 1'b0;
      ret_vld_r   <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
      iss_cnt_r   <= '0;
      cnt_r       <= '0;
      coef_data_r <= '0;
      coef_last_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      range_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_word_r  <= cur_word_s;
      pf_word_r   <= pf_word_s;
      cur_vld_r   <= cur_vld_s;
      pf_vld_r    <= pf_vld_s;
      ret_vld_r   <= rd_en_r;
      rd_en_r     <= issue_s;
      rd_addr_r   <= rd_addr_s;
      iss_cnt_r   <= iss_cnt_s;
      cnt_r       <= cnt_s;
      coef_data_r <= coef_data_s;
      coef_last_r <= coef_last_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      range_err_r <= range_err_s;
    end
  end

  assign bram_rd_en   = rd_en_r;
  assign bram_rd_addr = rd_addr_r;
  assign coef_data    = coef_data_r;
  assign coef_poly    = cnt_r[CNT_W-1];
  assign coef_idx     = cnt_r[7:0];
  assign coef_last    = coef_last_r;
  assign coef_valid   = cur_vld_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign range_err    = range_err_r;

endmodule

// File: tb/tb_ntt_polyvec_coef_streamer.sv
// Self-checking bench: a table of run scenarios, each streamed against a
// coefficient-array reference model with randomized backpressure.
module tb_ntt_polyvec_coef_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        bram_rd_en;
  logic [5:0]  bram_rd_addr;
  logic [95:0] bram_rd_data = '0;
  logic [11:0] coef_data;
  logic        coef_poly;
  logic [7:0]  coef_idx;
  logic        coef_last;
  logic        coef_valid;
  logic        coef_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        range_err;

  always #5 clk = ~clk;

  ntt_polyvec_coef_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .coef_data(coef_data), .coef_poly(coef_poly), .coef_idx(coef_idx),
    .coef_last(coef_last), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .busy(busy), .done(done), .range_err(range_err)
  );

  logic [95:0] mem_w [64];
  int          coef_mem [512];
  logic [5:0]  rd_log [$];

  // Synchronous-read BRAM model; every captured address is logged.
  always @(posedge clk) begin
    if (bram_rd_en) begin
      bram_rd_data <= mem_w[bram_rd_addr];
      rd_log.push_back(bram_rd_addr);
    end
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_image(input int kind);
    logic [95:0] w;
    for (int i = 0; i < 512; i++) coef_mem[i] = i;
    if (kind == 1) begin
      coef_mem[5*8+3] = 3329;
      coef_mem[40*8]  = 4095;
    end else if (kind == 2) begin
      coef_mem[100] = 3328;
    end
    for (int a = 0; a < 64; a++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w = (w << 12) | 96'(coef_mem[a*8+k] & 12'hFFF);
      mem_w[a] = w;
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bram_rd_en, bram_rd_addr, coef_data, coef_poly, coef_idx, coef_last,
                 coef_valid, busy, done, range_err}, 64'd0);
  endtask

  typedef struct {
    int pct;         // probability (percent) of coef_ready per cycle
    int img;         // 0 clean, 1 two unreduced values, 2 boundary 3328
    bit stall_last;  // hold ready low for 20 cycles on coef_last
    int abort_at;    // pulse reset when this many transfers are done (-1 none)
    bit spam;        // pulse start mid-stream and in the done cycle
    bit exp_err;     // expected final range_err
  } vec_t;

  task automatic run(input vec_t v);
    int c, t, first_c, done_c, stall_n, base, n;
    bit model_err, pend_err, exp_done, prev_stall, ok;
    logic [11:0] pd;
    logic pp, pl;
    logic [7:0] pi;
    c = 0; t = 0; first_c = -1; done_c = -1; stall_n = 0;
    model_err = 1'b0; pend_err = 1'b0; exp_done = 1'b0; prev_stall = 1'b0;
    pd = '0; pp = 1'b0; pl = 1'b0; pi = '0;
    load_image(v.img);
    base = rd_log.size();
    @(negedge clk); start = 1'b1; coef_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);
    check("range_err_cleared", range_err, 0);
    forever begin
      model_err = model_err | pend_err;
      pend_err = 1'b0;
      check("done", done, exp_done);
      if (exp_done) begin
        done_c = c;
        break;
      end
      if (c == 1) check("first_read_addr0", {bram_rd_en, bram_rd_addr}, {1'b1, 6'd0});
      if (coef_valid && first_c < 0) begin
        first_c = c;
        check("first_valid_cycle", c, 3);
      end
      if (prev_stall)
        check("stall_hold", {coef_valid, coef_data, coef_poly, coef_idx, coef_last},
              {1'b1, pd, pp, pi, pl});
      check("range_err", range_err, model_err);
      if (v.abort_at >= 0 && t == v.abort_at) begin
        rst_n = 1'b0; coef_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check_all_zero("reset_outputs");
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("after_abort", {coef_valid, done, busy, bram_rd_en}, 4'd0);
        end
        return;
      end
      if (v.stall_last && coef_valid && coef_last && stall_n < 20) begin
        coef_ready = 1'b0;
        stall_n++;
      end else begin
        coef_ready = ($urandom_range(99) < v.pct);
      end
      start = v.spam && (t == 200);
      if (coef_valid && coef_ready) begin
        check("coef", {coef_data, coef_poly, coef_idx, coef_last},
              {12'(coef_mem[t]), 1'(t / 256), 8'(t % 256), (t == 511)});
        pend_err = (coef_mem[t] >= 3329);
        if (t == 511) exp_done = 1'b1;
        t++;
      end
      prev_stall = coef_valid && !coef_ready;
      pd = coef_data; pp = coef_poly; pi = coef_idx; pl = coef_last;
      @(negedge clk);
      c++;
      if (c > 5000) begin
        n_vec++; n_fail++;
        $display("FAIL run_timeout: got %0d transfers expected 512", t);
        start = 1'b0;
        return;
      end
    end
    start = v.spam;
    coef_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    check("idle_after_done", {busy, done, coef_valid, bram_rd_en, bram_rd_addr}, 64'd0);
    check("transfer_count", t, 512);
    check("final_range_err", range_err, model_err);
    check("expected_range_err", range_err, v.exp_err);
    if (v.stall_last) check("last_stall_len", stall_n, 20);
    if (v.pct == 100 && !v.stall_last) check("no_bubble_done_cycle", done_c, 515);
    n = rd_log.size() - base;
    ok = (n == 64);
    for (int i = 0; i < 64 && ok; i++) ok = (rd_log[base+i] == 6'(i));
    check("addr_once_in_order", ok, 1);
  endtask

  initial begin
    vec_t tbl[8];
    tbl[0] = '{pct:100, img:0, stall_last:0, abort_at:-1,  spam:0, exp_err:0};
    tbl[1] = '{pct:50,  img:0, stall_last:0, abort_at:-1,  spam:0, exp_err:0};
    tbl[2] = '{pct:100, img:1, stall_last:0, abort_at:-1,  spam:0, exp_err:1};
    tbl[3] = '{pct:50,  img:1, stall_last:0, abort_at:-1,  spam:0, exp_err:1};
    tbl[4] = '{pct:100, img:2, stall_last:1, abort_at:-1,  spam:0, exp_err:0};
    tbl[5] = '{pct:70,  img:0, stall_last:0, abort_at:100, spam:0, exp_err:0};
    tbl[6] = '{pct:100, img:0, stall_last:0, abort_at:-1,  spam:1, exp_err:0};
    tbl[7] = '{pct:100, img:0, stall_last:0, abort_at:-1,  spam:0, exp_err:0};

    load_image(0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_state");

    for (int i = 0; i < 8; i++) run(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
